instruction_fetch_controller: RTL

Sequences the byte-addressed, combinational-read instruction memory. Holds the program counter and drives the memory address. Captures each returned 32-bit word, with its PC, into a 2-entry fetch buffer that decode drains over a valid/ready handshake. Handles branch redirects with a buffer flush, and halts on misaligned or out-of-range fetches.

---
 rtl/instruction_fetch_controller.sv | 125 ++++++++++++
 1 files changed

// File: rtl/instruction_fetch_controller.sv
// Instruction fetch controller: owns the PC and drives the memory address.
// Captures {word, pc} into a 2-entry FIFO for decode, with branch flush and sticky fault halt.
module instruction_fetch_controller #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          MEM_BYTES = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  output logic [31:0] fetch_address,
  input  logic [31:0] fetch_instruction,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instruction,
  output logic [31:0] out_pc,
  input  logic        branch_valid,
  input  logic [31:0] branch_target,
  output logic        fault
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HALT  = 2'd2
  } state_t;

  localparam logic [31:0] LAST_PC = 32'(MEM_BYTES - 4);

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [1:0]  count_q, count_d;
  logic        head_q, head_d;
  logic        fault_q, fault_d;
  logic [31:0] ent_instr_q [2];
  logic [31:0] ent_pc_q    [2];
  logic [31:0] ent_instr_d [2];
  logic [31:0] ent_pc_d    [2];

  logic pop_s, push_s, fault_cond_s, branch_take_s, tail_s;

  // Handshake, fault detection and FIFO/PC/state next-value logic.
  always_comb begin
    pop_s         = (count_q != 2'd0) & out_ready;
    branch_take_s = branch_valid & (state_q != HALT);
    fault_cond_s  = (state_q == FETCH) & enable & ~branch_valid &
                    ((pc_q[1:0] != 2'b00) | (pc_q > LAST_PC));
    push_s        = (state_q == FETCH) & enable & ~branch_valid & ~fault_cond_s &
                    ((count_q != 2'd2) | pop_s);
    // Tail slot is head+count mod 2; at count=2 with pop it reuses the slot being freed.
    tail_s        = head_q ^ count_q[0];

    state_d        = state_q;
    pc_d           = pc_q;
    count_d        = count_q;
    head_d         = head_q;
    fault_d        = fault_q | fault_cond_s;
    ent_instr_d[0] = ent_instr_q[0];
    ent_instr_d[1] = ent_instr_q[1];
    ent_pc_d[0]    = ent_pc_q[0];
    ent_pc_d[1]    = ent_pc_q[1];

    if (branch_take_s) begin
      pc_d    = branch_target;
      count_d = 2'd0;
      head_d  = 1'b0;
    end else begin
      if (push_s) begin
        ent_instr_d[tail_s] = fetch_instruction;
        ent_pc_d[tail_s]    = pc_q;
        pc_d                = pc_q + 32'd4;
      end else begin
        pc_d = pc_q;
      end
      count_d = count_q + {1'b0, push_s} - {1'b0, pop_s};
      head_d  = head_q ^ pop_s;
    end

    case (state_q)
      IDLE:    state_d = enable ? FETCH : IDLE;
      FETCH: begin
        if (fault_cond_s) begin
          state_d = HALT;
        end else if (!enable) begin
          state_d = IDLE;
        end else begin
          state_d = FETCH;
        end
      end
      HALT:    state_d = HALT;
      default: state_d = IDLE;
    endcase
  end

  // State, PC, FIFO and fault registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= IDLE;
      pc_q           <= RESET_PC;
      count_q        <= 2'd0;
      head_q         <= 1'b0;
      fault_q        <= 1'b0;
      ent_instr_q[0] <= 32'd0;
      ent_instr_q[1] <= 32'd0;
      ent_pc_q[0]    <= 32'd0;
      ent_pc_q[1]    <= 32'd0;
    end else begin
      state_q        <= state_d;
      pc_q           <= pc_d;
      count_q        <= count_d;
      head_q         <= head_d;
      fault_q        <= fault_d;
      ent_instr_q[0] <= ent_instr_d[0];
      ent_instr_q[1] <= ent_instr_d[1];
      ent_pc_q[0]    <= ent_pc_d[0];
      ent_pc_q[1]    <= ent_pc_d[1];
    end
  end

  assign fetch_address   = pc_q;
  assign out_valid       = (count_q != 2'd0);
  assign out_instruction = out_valid ? ent_instr_q[head_q] : 32'd0;
  assign out_pc          = out_valid ? ent_pc_q[head_q] : 32'd0;
  assign fault           = fault_q;

endmodule
